// File: rtl/rename_table_if.sv
// Rename-stage bus between the decode/allocate logic and the register rename table.
// The master drives the rename request; the rename table is the slave.
interface rename_table_if #(
    parameter int NUM_ISA_REGS    = 32,
    parameter int NUM_PHYS_REGS   = 64,
    parameter int NUM_CHECKPOINTS = 4
);
    localparam int ISA_W = $clog2(NUM_ISA_REGS);
    localparam int REG_W = $clog2(NUM_PHYS_REGS);
    localparam int CP_W  = $clog2(NUM_CHECKPOINTS);

    logic             rename_valid_i;
    logic [ISA_W-1:0] src1_i;
    logic [ISA_W-1:0] src2_i;
    logic [ISA_W-1:0] dst_i;
    logic             dst_write_i;
    logic [REG_W-1:0] new_dst_i;
    logic             checkpoint_i;
    logic             recover_i;
    logic [CP_W-1:0]  recover_id_i;
    logic             delete_checkpoint_i;

    logic [REG_W-1:0] src1_phys_o;
    logic [REG_W-1:0] src2_phys_o;
    logic [REG_W-1:0] old_dst_phys_o;
    logic             rename_valid_o;
    logic [CP_W-1:0]  checkpoint_id_o;
    logic             read_head_o;
    logic             out_of_checkpoints_o;

    modport master (
        output rename_valid_i, src1_i, src2_i, dst_i, dst_write_i, new_dst_i,
               checkpoint_i, recover_i, recover_id_i, delete_checkpoint_i,
        input  src1_phys_o, src2_phys_o, old_dst_phys_o, rename_valid_o,
               checkpoint_id_o, read_head_o, out_of_checkpoints_o
    );

    modport slave (
        input  rename_valid_i, src1_i, src2_i, dst_i, dst_write_i, new_dst_i,
               checkpoint_i, recover_i, recover_id_i, delete_checkpoint_i,
        output src1_phys_o, src2_phys_o, old_dst_phys_o, rename_valid_o,
               checkpoint_id_o, read_head_o, out_of_checkpoints_o
    );
endinterface

// File: rtl/rename_table.sv
// Architectural-to-physical register map with a circular buffer of branch snapshots
// for single-cycle mispredict recovery.
module rename_table #(
    parameter int NUM_ISA_REGS    = 32,
    parameter int NUM_PHYS_REGS   = 64,
    parameter int NUM_CHECKPOINTS = 4
) (
    input logic           clk_i,
    input logic           rstn_i,
    rename_table_if.slave rt
);
    localparam int ISA_W = $clog2(NUM_ISA_REGS);
    localparam int REG_W = $clog2(NUM_PHYS_REGS);
    localparam int CP_W  = $clog2(NUM_CHECKPOINTS);

    typedef logic [REG_W-1:0] reg_t;
    typedef logic [CP_W-1:0]  cp_t;
    typedef logic [CP_W:0]    cnt_t;

    reg_t map_q  [NUM_ISA_REGS];
    reg_t map_wr [NUM_ISA_REGS];
    reg_t snap_q [NUM_CHECKPOINTS][NUM_ISA_REGS];

    cp_t  head_q;
    cp_t  tail_q;
    cnt_t num_q;
    cp_t  rec_dist;

    reg_t src1_q;
    reg_t src2_q;
    reg_t old_dst_q;
    logic rename_valid_q;
    cp_t  cp_id_q;

    logic full;
    logic rename_ok;
    logic dst_alloc;
    logic take_cp;
    logic drop_cp;

    assign full      = (num_q == cnt_t'(NUM_CHECKPOINTS));
    assign rename_ok = rt.rename_valid_i & ~rt.recover_i;
    assign dst_alloc = rename_ok & rt.dst_write_i & (rt.dst_i != '0);
    assign take_cp   = rename_ok & rt.checkpoint_i & ~full;
    assign drop_cp   = rt.delete_checkpoint_i & ~rt.recover_i & (num_q != '0);
    assign rec_dist  = rt.recover_id_i - head_q;

    assign rt.read_head_o          = dst_alloc;
    assign rt.out_of_checkpoints_o = full;
    assign rt.src1_phys_o          = src1_q;
    assign rt.src2_phys_o          = src2_q;
    assign rt.old_dst_phys_o       = old_dst_q;
    assign rt.rename_valid_o       = rename_valid_q;
    assign rt.checkpoint_id_o      = cp_id_q;

    // A branch snapshot must include the branch's own destination write.
    always_comb begin
        for (int i = 0; i < NUM_ISA_REGS; i++) begin
            map_wr[i] = map_q[i];
        end
        if (dst_alloc) begin
            map_wr[rt.dst_i] = rt.new_dst_i;
        end
    end

    // Entry 0 is reset to zero and excluded from every write path.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_ISA_REGS; i++) begin
                map_q[i] <= reg_t'(i);
            end
        end else if (rt.recover_i) begin
            for (int i = 1; i < NUM_ISA_REGS; i++) begin
                map_q[i] <= snap_q[rt.recover_id_i][i];
            end
        end else if (dst_alloc) begin
            map_q[rt.dst_i] <= rt.new_dst_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (take_cp) begin
            snap_q[tail_q] <= map_wr;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q <= '0;
            tail_q <= '0;
            num_q  <= '0;
        end else if (rt.recover_i) begin
            tail_q <= rt.recover_id_i;
            num_q  <= {1'b0, rec_dist};
        end else begin
            if (take_cp) begin
                tail_q <= tail_q + cp_t'(1);
            end
            if (drop_cp) begin
                head_q <= head_q + cp_t'(1);
            end
            num_q <= num_q + cnt_t'(take_cp) - cnt_t'(drop_cp);
        end
    end

    // Lookups use the map as it stood before this instruction's own write.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            src1_q         <= '0;
            src2_q         <= '0;
            old_dst_q      <= '0;
            rename_valid_q <= 1'b0;
            cp_id_q        <= '0;
        end else begin
            rename_valid_q <= rename_ok;
            if (rename_ok) begin
                src1_q    <= map_q[rt.src1_i];
                src2_q    <= map_q[rt.src2_i];
                old_dst_q <= dst_alloc ? map_q[rt.dst_i] : '0;
                if (take_cp) begin
                    cp_id_q <= tail_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_rename_table.sv
// Randomized bench for rename_table against a plain-array reference model of the
// map table and the checkpoint ring.
module tb_rename_table;
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;

    rename_table_if #(.NUM_ISA_REGS(32), .NUM_PHYS_REGS(64), .NUM_CHECKPOINTS(4)) bus ();

    rename_table #(.NUM_ISA_REGS(32), .NUM_PHYS_REGS(64), .NUM_CHECKPOINTS(4)) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .rt    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    int m_map  [32];
    int m_snap [4][32];
    int m_head, m_tail, m_num;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = i;
        m_head = 0;
        m_tail = 0;
        m_num  = 0;
    endtask

    task automatic idle_inputs();
        bus.rename_valid_i      = 1'b0;
        bus.src1_i              = '0;
        bus.src2_i              = '0;
        bus.dst_i               = '0;
        bus.dst_write_i         = 1'b0;
        bus.new_dst_i           = '0;
        bus.checkpoint_i        = 1'b0;
        bus.recover_i           = 1'b0;
        bus.recover_id_i        = '0;
        bus.delete_checkpoint_i = 1'b0;
    endtask

    // One cycle: drive, check combinational outputs, clock, update model, check registered outputs.
    task automatic step(input bit rv, input int s1, input int s2, input int d, input bit dw,
                        input int nd, input bit cp, input bit rec, input int rid, input bit del);
        bit e_rv, e_pop, e_cp;
        int e_s1, e_s2, e_old, e_id, old_num;
        bus.rename_valid_i      = rv;
        bus.src1_i              = s1[4:0];
        bus.src2_i              = s2[4:0];
        bus.dst_i               = d[4:0];
        bus.dst_write_i         = dw;
        bus.new_dst_i           = nd[5:0];
        bus.checkpoint_i        = cp;
        bus.recover_i           = rec;
        bus.recover_id_i        = rid[1:0];
        bus.delete_checkpoint_i = del;
        #1;
        assert (!(rec && del)) else $error("recover and delete driven together");
        e_rv  = rv && !rec;
        e_pop = e_rv && dw && (d != 0);
        chk("read_head", int'(bus.read_head_o), int'(e_pop));
        chk("out_of_cp", int'(bus.out_of_checkpoints_o), int'(m_num == 4));
        e_s1  = m_map[s1];
        e_s2  = m_map[s2];
        e_old = e_pop ? m_map[d] : 0;
        e_cp  = e_rv && cp && (m_num < 4);
        e_id  = m_tail;
        old_num = m_num;
        if (rec) begin
            for (int i = 1; i < 32; i++) m_map[i] = m_snap[rid][i];
            m_tail = rid;
            m_num  = (((rid - m_head) % 4) + 4) % 4;
        end else begin
            if (e_pop) m_map[d] = nd;
            if (e_cp) begin
                for (int i = 0; i < 32; i++) m_snap[m_tail][i] = m_map[i];
                m_tail = (m_tail + 1) % 4;
                m_num++;
            end
            if (del && old_num > 0) begin
                m_head = (m_head + 1) % 4;
                m_num--;
            end
        end
        @(posedge clk_i);
        #1;
        chk("rename_valid", int'(bus.rename_valid_o), int'(e_rv));
        if (e_rv) begin
            chk("src1_phys", int'(bus.src1_phys_o), e_s1);
            chk("src2_phys", int'(bus.src2_phys_o), e_s2);
            chk("old_dst", int'(bus.old_dst_phys_o), e_old);
        end
        if (e_cp) chk("cp_id", int'(bus.checkpoint_id_o), e_id);
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn_i = 1'b0;
        #2;
        chk("rst_valid", int'(bus.rename_valid_o), 0);
        chk("rst_src1", int'(bus.src1_phys_o), 0);
        chk("rst_old_dst", int'(bus.old_dst_phys_o), 0);
        chk("rst_cp_id", int'(bus.checkpoint_id_o), 0);
        chk("rst_out_of_cp", int'(bus.out_of_checkpoints_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_hold_valid", int'(bus.rename_valid_o), 0);
        rstn_i = 1'b1;
        model_reset();
    endtask

    initial begin
        bit rv, dw, cp, rec, del;
        int rid;
        model_reset();
        apply_reset();

        // Basic rename, back-to-back dependency, x0 destination.
        step(1, 5, 0, 3, 1, 40, 0, 0, 0, 0);
        chk("d36_src1", int'(bus.src1_phys_o), 5);
        chk("d36_src2", int'(bus.src2_phys_o), 0);
        chk("d36_old", int'(bus.old_dst_phys_o), 3);
        step(1, 3, 0, 3, 1, 41, 0, 0, 0, 0);
        chk("d37_src1", int'(bus.src1_phys_o), 40);
        chk("d37_old", int'(bus.old_dst_phys_o), 40);
        step(1, 0, 0, 0, 1, 50, 0, 0, 0, 0);
        chk("d38_old", int'(bus.old_dst_phys_o), 0);
        step(1, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("d38_x0", int'(bus.src1_phys_o), 0);
        chk("d38_x3", int'(bus.src2_phys_o), 41);

        // Fill the checkpoint ring, overflow attempt, then release the oldest.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, k, 0, 10 + k, 1, 20 + k, 1, 0, 0, 0);
            chk("d39_id", int'(bus.checkpoint_id_o), k);
        end
        chk("d39_full", int'(bus.out_of_checkpoints_o), 1);
        step(1, 0, 0, 15, 1, 30, 1, 0, 0, 0);
        chk("d39_ignored_id", int'(bus.checkpoint_id_o), 3);
        chk("d39_still_full", int'(bus.out_of_checkpoints_o), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("d39_not_full", int'(bus.out_of_checkpoints_o), 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("d39_wrap_id", int'(bus.checkpoint_id_o), 0);

        // Mispredict recovery to the first snapshot.
        apply_reset();
        step(1, 0, 0, 7, 1, 42, 1, 0, 0, 0);
        step(1, 0, 0, 7, 1, 43, 1, 0, 0, 0);
        chk("d40_id1", int'(bus.checkpoint_id_o), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 7, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("d40_src1", int'(bus.src1_phys_o), 42);
        chk("d40_id0", int'(bus.checkpoint_id_o), 0);

        // Recover collides with a rename: the rename is dropped.
        step(1, 7, 0, 7, 1, 44, 1, 1, 0, 0);
        chk("d41_dropped", int'(bus.rename_valid_o), 0);
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("d41_map", int'(bus.src1_phys_o), 42);

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) apply_reset();
            rv  = ($urandom_range(9) < 8);
            dw  = ($urandom_range(3) != 0);
            cp  = ($urandom_range(9) < 3);
            rec = 1'b0;
            rid = 0;
            del = 1'b0;
            if (m_num > 0 && $urandom_range(15) == 0) begin
                rec = 1'b1;
                rid = (m_head + $urandom_range(m_num - 1)) % 4;
            end else if ($urandom_range(7) == 0) begin
                del = 1'b1;
            end
            step(rv, $urandom_range(31), $urandom_range(31), $urandom_range(31), dw,
                 $urandom_range(63), cp, rec, rid, del);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
